// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types and defaults for the APB master arbiter
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  // Requester index visited at step 'off' of a round-robin scan starting at 'ptr'.
  function automatic int rr_index(input int ptr, input int off, input int n);
    return (ptr + off) % n;
  endfunction

endpackage

// File: rtl/apb_if.sv
// rtl/apb_if.sv - APB signal bundle with master/slave views
interface apb_if
  import apb_pkg::*;
#(
  parameter int ADDR_W = APB_ADDR_W,
  parameter int DATA_W = APB_DATA_W
) ();

  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic              pready;
  logic [DATA_W-1:0] prdata;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  pready, prdata
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output pready, prdata
  );

endinterface

// File: rtl/apb_rr_arbiter.sv
// rtl/apb_rr_arbiter.sv - combinational round-robin grant starting at rr_ptr
module apb_rr_arbiter
  import apb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       grant_any
);

  localparam int ID_W = $clog2(NUM_REQ);

  logic [ID_W-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    idx       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = ID_W'(rr_index(int'(rr_ptr), i, NUM_REQ));
      if (!grant_any && req_valid[idx]) begin
        grant[idx] = 1'b1;
        grant_id   = idx;
        grant_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// rtl/apb_master_arbiter.sv - round-robin sharing of one APB master port
module apb_master_arbiter
  import apb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic                       pclk,
  input  logic                       preset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic                       rsp_err,
  output logic                       busy,
  apb_if.master                      apb
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam int TO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  apb_state_e        state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   cur_id_q, cur_id_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_id;
  logic               grant_any;

  apb_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr_q),
    .grant     (grant),
    .grant_id  (grant_id),
    .grant_any (grant_any)
  );

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    cur_id_d    = cur_id_q;
    to_cnt_d    = to_cnt_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      IDLE: begin
        if (grant_any) begin
          pwrite_d = req_write[grant_id];
          paddr_d  = req_addr[int'(grant_id)*ADDR_W +: ADDR_W];
          pwdata_d = req_wdata[int'(grant_id)*DATA_W +: DATA_W];
          cur_id_d = grant_id;
          rr_ptr_d = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
          psel_d   = 1'b1;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        to_cnt_d  = '0;
        state_d   = ACCESS;
      end
      ACCESS: begin
        // A ready slave takes priority over a timeout expiring in the same cycle.
        if (psel_q && penable_q && apb.pready) begin
          rsp_valid_d = 1'b1;
          rsp_id_d    = cur_id_q;
          rsp_rdata_d = pwrite_q ? '0 : apb.prdata;
          rsp_err_d   = 1'b0;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          state_d     = IDLE;
        end else if ((TIMEOUT != 0) && (to_cnt_q == TO_LAST)) begin
          rsp_valid_d = 1'b1;
          rsp_id_d    = cur_id_q;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          state_d     = IDLE;
        end else if (to_cnt_q != '1) begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      cur_id_q    <= '0;
      to_cnt_q    <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      cur_id_q    <= cur_id_d;
      to_cnt_q    <= to_cnt_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // The accept pulse is combinational so a grant lands in the same cycle the FSM sits in IDLE.
  assign req_ready   = (state_q == IDLE && !preset) ? grant : '0;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign busy        = (state_q != IDLE);
  assign apb.psel    = psel_q;
  assign apb.penable = penable_q;
  assign apb.pwrite  = pwrite_q;
  assign apb.paddr   = paddr_q;
  assign apb.pwdata  = pwdata_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb/tb_apb_master_arbiter.sv - directed self-checking bench for apb_master_arbiter
module tb_apb_master_arbiter;
  import apb_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  logic                      pclk   = 1'b0;
  logic                      preset = 1'b1;
  logic [NUM_REQ-1:0]        req_valid = '0;
  logic [NUM_REQ-1:0]        req_write = '0;
  logic [NUM_REQ*ADDR_W-1:0] req_addr  = '0;
  logic [NUM_REQ*DATA_W-1:0] req_wdata = '0;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      rsp_valid;
  logic [1:0]                rsp_id;
  logic [DATA_W-1:0]         rsp_rdata;
  logic                      rsp_err;
  logic                      busy;

  int checks = 0;
  int errors = 0;

  apb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  apb_master_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .pclk      (pclk),
    .preset    (preset),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .apb       (bus.master)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge pclk);
    #1;
  endtask

  task automatic set_req(input int id, input logic wr, input logic [31:0] a, input logic [31:0] d);
    req_valid[id] = 1'b1;
    req_write[id] = wr;
    req_addr[id*ADDR_W +: ADDR_W]  = a;
    req_wdata[id*DATA_W +: DATA_W] = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n;
    int last;
    int acc;
    int early;

    bus.pready = 1'b0;
    bus.prdata = '0;
    #1;
    check("rst_psel", bus.psel, 0);
    check("rst_penable", bus.penable, 0);
    check("rst_paddr", bus.paddr, 0);
    check("rst_pwdata", bus.pwdata, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_busy", busy, 0);
    check("rst_req_ready", req_ready, 0);
    tick;
    tick;
    preset = 1'b0;

    // single write, zero wait
    bus.pready = 1'b1;
    set_req(0, 1'b1, 32'h10, 32'hA5A5_0001);
    #1;
    check("wr_req_ready", req_ready, 4'b0001);
    check("wr_busy_idle", busy, 0);
    tick;
    req_valid = '0;
    check("wr_setup_psel", bus.psel, 1);
    check("wr_setup_penable", bus.penable, 0);
    check("wr_paddr", bus.paddr, 32'h10);
    check("wr_pwrite", bus.pwrite, 1);
    check("wr_pwdata", bus.pwdata, 32'hA5A5_0001);
    tick;
    check("wr_access_penable", bus.penable, 1);
    check("wr_no_early_rsp", rsp_valid, 0);
    tick;
    check("wr_rsp_valid", rsp_valid, 1);
    check("wr_rsp_id", rsp_id, 0);
    check("wr_rsp_err", rsp_err, 0);
    check("wr_rsp_rdata", rsp_rdata, 0);
    check("wr_psel_drop", bus.psel, 0);
    check("wr_busy_done", busy, 0);

    // read with two wait states from requester 2
    bus.pready = 1'b0;
    set_req(2, 1'b0, 32'h20, 32'h0);
    #1;
    check("rd_req_ready", req_ready, 4'b0100);
    tick;
    req_valid = '0;
    check("rd_paddr", bus.paddr, 32'h20);
    check("rd_pwrite", bus.pwrite, 0);
    tick;
    check("rd_penable_1", bus.penable, 1);
    tick;
    check("rd_penable_2", bus.penable, 1);
    bus.pready = 1'b1;
    bus.prdata = 32'hDEAD_BEEF;
    check("rd_penable_3", bus.penable, 1);
    check("rd_no_early_rsp", rsp_valid, 0);
    tick;
    check("rd_rsp_valid", rsp_valid, 1);
    check("rd_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
    check("rd_rsp_id", rsp_id, 2);
    check("rd_rsp_err", rsp_err, 0);
    check("rd_penable_drop", bus.penable, 0);
    bus.pready = 1'b0;
    bus.prdata = '0;

    // reset during ACCESS; pointer is 3 so requester 1 wins by wrapping
    set_req(1, 1'b1, 32'h40, 32'h55);
    #1;
    check("rst_mid_req_ready", req_ready, 4'b0010);
    tick;
    req_valid = '0;
    tick;
    check("rst_mid_in_access", bus.penable, 1);
    #2;
    preset = 1'b1;
    #1;
    check("rst_mid_psel", bus.psel, 0);
    check("rst_mid_penable", bus.penable, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_rsp_valid", rsp_valid, 0);
    tick;
    check("rst_mid_rsp_valid_hold", rsp_valid, 0);
    preset = 1'b0;

    // round robin with all requesters continuously valid
    bus.pready = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 32'h100 + i * 4, i);
    #1;
    n = 0;
    last = -1;
    for (int c = 0; c < 20 && n < 5; c++) begin
      if (req_ready != '0) begin
        check("rr_grant", req_ready, 4'b0001 << (n % NUM_REQ));
        if (n > 0) check("rr_gap", c - last, 3);
        last = c;
        n++;
      end
      tick;
    end
    check("rr_count", n, 5);
    req_valid = '0;
    for (int c = 0; c < 10; c++) begin
      tick;
      if (rsp_valid) break;
    end
    check("rr_last_rsp_valid", rsp_valid, 1);
    check("rr_last_rsp_id", rsp_id, 0);

    // pready arrives on the final ACCESS cycle before timeout
    bus.pready = 1'b0;
    set_req(3, 1'b0, 32'h50, 32'h0);
    #1;
    check("tvr_req_ready", req_ready, 4'b1000);
    tick;
    req_valid = '0;
    acc = 0;
    early = 0;
    for (int k = 1; k <= TIMEOUT; k++) begin
      tick;
      if (bus.penable) acc++;
      if (rsp_valid) early++;
      if (k == TIMEOUT) begin
        bus.pready = 1'b1;
        bus.prdata = 32'h1234_5678;
      end
    end
    check("tvr_no_early_rsp", early, 0);
    check("tvr_access_cycles", acc, TIMEOUT);
    tick;
    check("tvr_rsp_valid", rsp_valid, 1);
    check("tvr_rsp_err", rsp_err, 0);
    check("tvr_rsp_rdata", rsp_rdata, 32'h1234_5678);
    check("tvr_rsp_id", rsp_id, 3);
    bus.pready = 1'b0;
    bus.prdata = '0;

    // timeout with pready held low
    set_req(0, 1'b0, 32'h30, 32'h0);
    #1;
    check("to_req_ready", req_ready, 4'b0001);
    tick;
    req_valid = '0;
    acc = 0;
    for (int c = 0; c < 40; c++) begin
      tick;
      if (rsp_valid) break;
      if (bus.penable) acc++;
    end
    check("to_rsp_valid", rsp_valid, 1);
    check("to_access_cycles", acc, TIMEOUT);
    check("to_rsp_err", rsp_err, 1);
    check("to_rsp_rdata", rsp_rdata, 0);
    check("to_rsp_id", rsp_id, 0);
    check("to_busy", busy, 0);
    tick;
    check("to_psel_after", bus.psel, 0);
    check("to_rsp_pulse", rsp_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
